store_merge_buffer: RTL and testbench
=====================================

// Module: store_merge_buffer
// PURPOSE
//  Parametrised store path between the LSU and the data cache.
//  - Accepts byte, half, word (and dword when WIDTH=64) stores.
//  - Builds byte-lane masks and buffers stores in a DEPTH-entry FIFO.
//  - Combines back-to-back stores to the same word.
//  - Drains each entry by read-modify-write of one cache word; a full-mask entry skips the read.
// PARAMETERS
//  WIDTH       32  data/cache word width in bits; multiple of 8, 32 or 64
//  ADDR_WIDTH  32  byte address width
//  DEPTH       4   FIFO entries; power of 2, >=2
// PORTS
//  clk          in   1           rising-edge clock
//  rst_n        in   1           asynchronous active-low reset
//  st_valid     in   1           store request valid
//  st_ready     out  1           buffer can accept this cycle
//  st_addr      in   ADDR_WIDTH  byte address of store
//  st_data      in   WIDTH       store data, right-aligned (bytes taken from LSBs)
//  st_size      in   2           log2(bytes): 0=B 1=H 2=W 3=D (3 legal only if WIDTH=64)
//  c_rd_en      out  1           cache word read request
//  c_wr_en      out  1           cache word write
//  c_addr       out  ADDR_WIDTH  word-aligned cache address (low log2(WIDTH/8) bits = 0)
//  c_rd_data    in   WIDTH       read data, valid exactly 1 cycle after c_rd_en
//  c_wr_data    out  WIDTH       merged write data
//  empty        out  1           no valid entries and FSM in IDLE
//  misalign_err out  1           1-cycle pulse: store rejected (misaligned or illegal size)
// BEHAVIOUR
//  - Reset (async, rst_n=0): all entries invalid, count=0, FSM=IDLE.
//    Outputs: c_rd_en=c_wr_en=misalign_err=0, c_addr=c_wr_data=0, empty=1, st_ready=1.
//    A drain in progress is abandoned; no write is issued.
//  - Accept on st_valid & st_ready. st_ready = (count < DEPTH).
//  - Lanes: nbytes = 1<<st_size, off = st_addr mod (WIDTH/8).
//    mask = ((1<<nbytes)-1) << off; lane data = st_data << (8*off).
//  - Misaligned (off mod nbytes != 0), or st_size > log2(WIDTH/8):
//    store is consumed (handshake completes), nothing is buffered,
//    misalign_err=1 on the next cycle.
//  - Combining: if newest valid entry has the same word address and is not locked,
//    merge into it (new bytes overwrite masked lanes, mask |= new mask); count unchanged.
//    Otherwise allocate at tail.
//  - Entry = {word addr, WIDTH data, WIDTH/8 mask}.
//  - Drain FSM, head entry only; head becomes locked when FSM leaves IDLE:
//    IDLE: count>0 & mask all-ones -> WR; count>0 & partial mask -> RD; else stay.
//    RD:   c_rd_en=1, c_addr=head addr -> WR.
//    WR:   c_wr_en=1, c_addr=head addr.
//          c_wr_data = per byte: mask ? entry byte : c_rd_data byte
//          (c_rd_data is ignored for a full-mask entry).
//          Pop head -> IDLE.
//  - Latency per entry: 2 cycles full mask, 3 cycles partial mask, counted from IDLE decision.
//  - c_rd_en/c_wr_en are never high together.
//  - Outputs are registered; c_addr/c_wr_data hold 0 when no request is asserted.
//  - Simultaneous accept and pop in WR: count unchanged. Accept at count=DEPTH is
//    impossible (st_ready=0) even if a pop occurs that cycle.
//  - A store to the head's word while the head is locked allocates a new entry
//    (it never merges into a locked entry). Order to cache = program order.
//  - Head/tail pointers wrap mod DEPTH.
// TESTING
//  1. Reset, SW 0x100 data 0xDEADBEEF -> c_wr_en, no c_rd_en;
//     c_addr=0x100, c_wr_data=0xDEADBEEF 2 cycles after IDLE sees entry.
//  2. SB 0x203 data 0xAB, cache word 0x11223344 -> RD then WR, c_wr_data=0xAB223344.
//  3. SH 0x300 0x5566, then SH 0x302 0x7788 back-to-back while FSM busy on other entry
//     -> single entry, full mask, one write 0x77885566, no read.
//  4. SH 0x401 -> store consumed, misalign_err pulses once, empty stays 1.
//  5. Stall the cache path and issue DEPTH+1 stores to distinct words -> st_ready=0 at count=DEPTH.
//     Stores drain in order; pointer wrap verified.
//  6. Deassert rst_n during RD -> outputs 0, empty=1 immediately.
//     After release, no write is issued for abandoned entries.

Source files
------------

// File: rtl/store_merge_buffer.sv
// Store merge buffer between the LSU and the data cache. Stores are lane-aligned, combined per word
// in a small FIFO, and drained in order by a read-modify-write of one cache word per entry.
module store_merge_buffer #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  st_valid,
  output logic                  st_ready,
  input  logic [ADDR_WIDTH-1:0] st_addr,
  input  logic [WIDTH-1:0]      st_data,
  input  logic [1:0]            st_size,
  output logic                  c_rd_en,
  output logic                  c_wr_en,
  output logic [ADDR_WIDTH-1:0] c_addr,
  input  logic [WIDTH-1:0]      c_rd_data,
  output logic [WIDTH-1:0]      c_wr_data,
  output logic                  empty,
  output logic                  misalign_err
);

  localparam int NB   = int'(WIDTH / 8);
  localparam int OFFW = $clog2(NB);
  localparam int PW   = $clog2(DEPTH);
  localparam int CW   = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {StIdle, StRd, StWr} state_e;

  state_e                state_q;
  logic [CW-1:0]         count_q;
  logic [PW-1:0]         head_q, tail_q, newest;
  logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
  logic [WIDTH-1:0]      data_q [DEPTH];
  logic [NB-1:0]         mask_q [DEPTH];

  logic [OFFW-1:0]       off;
  logic [ADDR_WIDTH-1:0] word_addr;
  logic [NB-1:0]         new_mask;
  logic [WIDTH-1:0]      new_data;
  logic                  bad, accept, push, merge, alloc, pop, head_locked;

  always_comb begin
    off       = st_addr[OFFW-1:0];
    word_addr = {st_addr[ADDR_WIDTH-1:OFFW], {OFFW{1'b0}}};
    new_data  = st_data << {off, 3'b000};
    for (int b = 0; b < NB; b++) begin
      new_mask[b] = (b >= int'(off)) && (b < int'(off) + (1 << st_size));
    end
    bad = (int'(st_size) > OFFW) || ((int'(off) & ((1 << st_size) - 1)) != 0);
  end

  assign st_ready    = count_q < CW'(DEPTH);
  assign empty       = (count_q == '0) && (state_q == StIdle);
  assign accept      = st_valid && st_ready;
  assign push        = accept && !bad;
  assign newest      = tail_q - PW'(1);
  // The head is claimed in the same cycle IDLE sees it, so a merge can never race the drain.
  assign head_locked = (state_q != StIdle) || (count_q != '0);
  assign merge       = push && (count_q != '0) && (addr_q[newest] == word_addr) &&
                       !((newest == head_q) && head_locked);
  assign alloc       = push && !merge;
  assign pop         = (state_q == StWr);

  // Read data only arrives in the WR cycle, so the byte merge is a mux after the registers.
  always_comb begin
    c_wr_data = '0;
    if (c_wr_en) begin
      for (int b = 0; b < NB; b++) begin
        c_wr_data[8*b +: 8] = mask_q[head_q][b] ? data_q[head_q][8*b +: 8]
                                                : c_rd_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      count_q      <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      c_rd_en      <= 1'b0;
      c_wr_en      <= 1'b0;
      c_addr       <= '0;
      misalign_err <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
        mask_q[i] <= '0;
      end
    end else begin
      misalign_err <= accept && bad;

      if (merge) begin
        for (int b = 0; b < NB; b++) begin
          if (new_mask[b]) data_q[newest][8*b +: 8] <= new_data[8*b +: 8];
        end
        mask_q[newest] <= mask_q[newest] | new_mask;
      end else if (alloc) begin
        addr_q[tail_q] <= word_addr;
        data_q[tail_q] <= new_data;
        mask_q[tail_q] <= new_mask;
        tail_q         <= tail_q + PW'(1);
      end

      if (pop) head_q <= head_q + PW'(1);
      count_q <= count_q + CW'(alloc) - CW'(pop);

      unique case (state_q)
        StIdle: begin
          if (count_q != '0) begin
            c_addr <= addr_q[head_q];
            if (&mask_q[head_q]) begin
              state_q <= StWr;
              c_wr_en <= 1'b1;
            end else begin
              state_q <= StRd;
              c_rd_en <= 1'b1;
            end
          end
        end
        StRd: begin
          state_q <= StWr;
          c_rd_en <= 1'b0;
          c_wr_en <= 1'b1;
        end
        StWr: begin
          state_q <= StIdle;
          c_wr_en <= 1'b0;
          c_addr  <= '0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_store_merge_buffer.sv
// Directed bench for store_merge_buffer: one task per scenario, inline comparisons against
// hand-computed cache traffic.
module tb_store_merge_buffer;

  localparam int W  = 32;
  localparam int AW = 32;
  localparam int D  = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          st_valid = 1'b0;
  logic          st_ready;
  logic [AW-1:0] st_addr = '0;
  logic [W-1:0]  st_data = '0;
  logic [1:0]    st_size = '0;
  logic          c_rd_en, c_wr_en;
  logic [AW-1:0] c_addr;
  logic [W-1:0]  c_rd_data = '0;
  logic [W-1:0]  c_wr_data;
  logic          empty, misalign_err;

  logic [W-1:0]  cache_word = '0;
  int            n_checks = 0;
  int            n_fail = 0;
  logic [AW-1:0] wr_addr_log[$];
  logic [W-1:0]  wr_data_log[$];
  int            rd_cnt = 0;
  int            overlap_cnt = 0;
  int            idle_junk = 0;

  store_merge_buffer #(.WIDTH(W), .ADDR_WIDTH(AW), .DEPTH(D)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .st_valid     (st_valid),
    .st_ready     (st_ready),
    .st_addr      (st_addr),
    .st_data      (st_data),
    .st_size      (st_size),
    .c_rd_en      (c_rd_en),
    .c_wr_en      (c_wr_en),
    .c_addr       (c_addr),
    .c_rd_data    (c_rd_data),
    .c_wr_data    (c_wr_data),
    .empty        (empty),
    .misalign_err (misalign_err)
  );

  always #5 clk = ~clk;

  // Cache model: read data returned one cycle after the read request.
  always @(posedge clk) c_rd_data <= c_rd_en ? cache_word : '0;

  always @(negedge clk) begin
    if (c_wr_en) begin
      wr_addr_log.push_back(c_addr);
      wr_data_log.push_back(c_wr_data);
    end
    if (c_rd_en) rd_cnt++;
    if (c_rd_en && c_wr_en) overlap_cnt++;
    if (!c_rd_en && !c_wr_en && (c_addr != '0 || c_wr_data != '0)) idle_junk++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [AW-1:0] a, input logic [W-1:0] d, input logic [1:0] s);
    st_valid = 1'b1; st_addr = a; st_data = d; st_size = s;
    n_checks++;
    if (st_ready !== 1'b1) begin
      n_fail++; $display("FAIL store_ready addr=%h: st_ready=%b required 1", a, st_ready);
    end
    tick();
    st_valid = 1'b0;
  endtask

  task automatic wait_empty(input string tag);
    int k;
    for (k = 0; k < 200 && empty !== 1'b1; k++) tick();
    n_checks++;
    if (empty !== 1'b1) begin
      n_fail++; $display("FAIL %s drain_timeout: empty=%b required 1", tag, empty);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({c_rd_en, c_wr_en, misalign_err} !== 3'b000) begin
      n_fail++; $display("FAIL reset_ctrl: rd/wr/err=%b required 000",
                         {c_rd_en, c_wr_en, misalign_err});
    end
    n_checks++;
    if (c_addr !== '0 || c_wr_data !== '0) begin
      n_fail++; $display("FAIL reset_bus: addr=%h data=%h required 0", c_addr, c_wr_data);
    end
    n_checks++;
    if (empty !== 1'b1 || st_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_status: empty=%b ready=%b required 1 1", empty, st_ready);
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_full_word();
    int rd0 = rd_cnt;
    cache_word = 32'hFFFF_FFFF;
    store(32'h100, 32'hDEAD_BEEF, 2'd2);
    n_checks++;
    if (c_wr_en !== 1'b0) begin
      n_fail++; $display("FAIL sw_decision_cycle: c_wr_en=%b required 0", c_wr_en);
    end
    tick();
    n_checks++;
    if (c_wr_en !== 1'b1 || c_rd_en !== 1'b0) begin
      n_fail++; $display("FAIL sw_write_cycle: wr=%b rd=%b required 1 0", c_wr_en, c_rd_en);
    end
    n_checks++;
    if (c_addr !== 32'h100 || c_wr_data !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL sw_write_value: addr=%h data=%h required 00000100 deadbeef",
                         c_addr, c_wr_data);
    end
    wait_empty("sw");
    n_checks++;
    if (rd_cnt !== rd0) begin
      n_fail++; $display("FAIL sw_no_read: reads=%0d required 0", rd_cnt - rd0);
    end
  endtask

  task automatic test_byte_rmw();
    cache_word = 32'h1122_3344;
    store(32'h203, 32'h0000_00AB, 2'd0);
    tick();
    n_checks++;
    if (c_rd_en !== 1'b1 || c_addr !== 32'h200) begin
      n_fail++; $display("FAIL sb_read: rd=%b addr=%h required 1 00000200", c_rd_en, c_addr);
    end
    tick();
    n_checks++;
    if (c_wr_en !== 1'b1 || c_wr_data !== 32'hAB22_3344) begin
      n_fail++; $display("FAIL sb_write: wr=%b data=%h required 1 ab223344", c_wr_en, c_wr_data);
    end
    wait_empty("sb");
  endtask

  task automatic test_combine();
    int base = wr_addr_log.size();
    int rd0 = rd_cnt;
    cache_word = 32'h1122_3344;
    store(32'h600, 32'h0000_0001, 2'd0);
    store(32'h300, 32'h0000_5566, 2'd1);
    store(32'h302, 32'h0000_7788, 2'd1);
    wait_empty("combine");
    n_checks++;
    if (wr_addr_log.size() != base + 2) begin
      n_fail++; $display("FAIL combine_write_count: writes=%0d required 2",
                         wr_addr_log.size() - base);
    end else begin
      n_checks++;
      if (wr_addr_log[base] !== 32'h600 || wr_data_log[base] !== 32'h1122_3301) begin
        n_fail++; $display("FAIL combine_first: addr=%h data=%h required 00000600 11223301",
                           wr_addr_log[base], wr_data_log[base]);
      end
      n_checks++;
      if (wr_addr_log[base+1] !== 32'h300 || wr_data_log[base+1] !== 32'h7788_5566) begin
        n_fail++; $display("FAIL combine_merged: addr=%h data=%h required 00000300 77885566",
                           wr_addr_log[base+1], wr_data_log[base+1]);
      end
    end
    n_checks++;
    if (rd_cnt - rd0 != 1) begin
      n_fail++; $display("FAIL combine_reads: reads=%0d required 1", rd_cnt - rd0);
    end
  endtask

  task automatic test_misalign();
    int base = wr_addr_log.size();
    store(32'h401, 32'h0000_1234, 2'd1);
    n_checks++;
    if (misalign_err !== 1'b1 || empty !== 1'b1) begin
      n_fail++; $display("FAIL sh_misalign: err=%b empty=%b required 1 1", misalign_err, empty);
    end
    tick();
    n_checks++;
    if (misalign_err !== 1'b0) begin
      n_fail++; $display("FAIL misalign_pulse: err=%b required 0", misalign_err);
    end
    store(32'h400, 32'h0000_0000, 2'd3);
    n_checks++;
    if (misalign_err !== 1'b1) begin
      n_fail++; $display("FAIL dword_illegal: err=%b required 1", misalign_err);
    end
    repeat (5) tick();
    n_checks++;
    if (wr_addr_log.size() != base || empty !== 1'b1) begin
      n_fail++; $display("FAIL misalign_no_write: writes=%0d empty=%b required 0 1",
                         wr_addr_log.size() - base, empty);
    end
  endtask

  task automatic test_back_to_back();
    int  base = wr_addr_log.size();
    int  i = 0;
    int  cyc = 0;
    bit  saw_full = 1'b0;
    bit  taken;
    cache_word = 32'hCAFE_F00D;
    while (i < D + 2 && cyc < 100) begin
      st_valid = 1'b1; st_addr = 32'h500 + 32'(4 * i); st_data = 32'h10 + 32'(i); st_size = 2'd0;
      if (st_ready === 1'b0) saw_full = 1'b1;
      taken = (st_ready === 1'b1);
      tick();
      cyc++;
      if (taken) i++;
    end
    st_valid = 1'b0;
    n_checks++;
    if (i != D + 2) begin
      n_fail++; $display("FAIL fill_accepts: accepted=%0d required %0d", i, D + 2);
    end
    n_checks++;
    if (!saw_full) begin
      n_fail++; $display("FAIL fill_backpressure: st_ready low seen=%b required 1", saw_full);
    end
    wait_empty("fill");
    n_checks++;
    if (wr_addr_log.size() != base + D + 2) begin
      n_fail++; $display("FAIL fill_write_count: writes=%0d required %0d",
                         wr_addr_log.size() - base, D + 2);
    end else begin
      for (int k = 0; k < D + 2; k++) begin
        n_checks++;
        if (wr_addr_log[base+k] !== 32'h500 + 32'(4 * k) ||
            wr_data_log[base+k] !== {24'hCAFEF0, 8'(8'h10 + k)}) begin
          n_fail++; $display("FAIL fill_order[%0d]: addr=%h data=%h required %h cafef0%h", k,
                             wr_addr_log[base+k], wr_data_log[base+k], 32'h500 + 32'(4 * k),
                             8'(8'h10 + k));
        end
      end
    end
  endtask

  task automatic test_reset_during_rd();
    int base = wr_addr_log.size();
    cache_word = 32'h0000_0055;
    store(32'h700, 32'h0000_00EE, 2'd0);
    store(32'h704, 32'h0000_00DD, 2'd0);
    n_checks++;
    if (c_rd_en !== 1'b1) begin
      n_fail++; $display("FAIL rst_rd_setup: c_rd_en=%b required 1", c_rd_en);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({c_rd_en, c_wr_en} !== 2'b00 || c_addr !== '0 || c_wr_data !== '0) begin
      n_fail++; $display("FAIL rst_rd_outputs: rd=%b wr=%b addr=%h data=%h required 0",
                         c_rd_en, c_wr_en, c_addr, c_wr_data);
    end
    n_checks++;
    if (empty !== 1'b1 || st_ready !== 1'b1) begin
      n_fail++; $display("FAIL rst_rd_status: empty=%b ready=%b required 1 1", empty, st_ready);
    end
    tick(); tick();
    rst_n = 1'b1;
    repeat (10) tick();
    n_checks++;
    if (wr_addr_log.size() != base || empty !== 1'b1) begin
      n_fail++; $display("FAIL rst_rd_abandon: writes=%0d empty=%b required 0 1",
                         wr_addr_log.size() - base, empty);
    end
  endtask

  task automatic test_protocol();
    n_checks++;
    if (overlap_cnt != 0) begin
      n_fail++; $display("FAIL rd_wr_overlap: cycles=%0d required 0", overlap_cnt);
    end
    n_checks++;
    if (idle_junk != 0) begin
      n_fail++; $display("FAIL idle_bus_zero: cycles=%0d required 0", idle_junk);
    end
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_byte_rmw();
    test_combine();
    test_misalign();
    test_back_to_back();
    test_reset_during_rd();
    test_protocol();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
